tensor_quantizer: RTL and testbench

- Streaming int32 → int8 quantizer; the initiator side of the scale calculator's start/ready handshake.
- Takes a tensor's max_abs and element count, drives the scale calculator to obtain reciprocal_scale (Q8.24 value of 127/max_abs), then quantizes num_elems signed 32-bit activations.
- Quantization: q = sat127(round(x * recip / 2^24)).
- Sits between the accumulator output buffer and the int8 activation buffer.

---
 rtl/tensor_quantizer.sv | 98 +++++++++
 tb/tb_tensor_quantizer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/tensor_quantizer.sv
// tensor_quantizer: streaming int32 -> int8 quantizer that fetches 127/max_abs from the scale calculator
module tensor_quantizer #(
    parameter int CNT_W     = 16,
    parameter int FRAC_BITS = 24
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cfg_start,
    input  logic [31:0]      cfg_max_abs,
    input  logic [CNT_W-1:0] cfg_num_elems,
    output logic             scale_start,
    output logic [31:0]      scale_max_abs,
    input  logic             scale_ready,
    input  logic [31:0]      reciprocal_scale,
    input  logic             in_valid,
    input  logic [31:0]      in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [7:0]       out_data,
    input  logic             out_ready,
    output logic             busy,
    output logic             done
);
    typedef enum logic [2:0] {IDLE, REQ, WAIT, STREAM, DRAIN} state_t;
    state_t state;
    logic [31:0] recip_q;
    logic [CNT_W-1:0] num_q, cnt;
    logic s1_valid;
    logic signed [63:0] s1_prod, prod, rnd, r;
    logic stall, accept;
    logic [7:0] q;
    assign scale_start   = state == REQ;
    assign busy          = state != IDLE;
    // handshake, full-width product and round-half-up-then-saturate datapath
    always_comb begin
        stall    = out_valid && !out_ready;
        in_ready = state == STREAM && !stall;
        accept   = in_valid && in_ready;
        prod     = {{32{in_data[31]}}, in_data} * {32'b0, recip_q};
        rnd      = s1_prod + (64'sd1 <<< (FRAC_BITS - 1));
        r        = rnd >>> FRAC_BITS;
        q        = r > 64'sd127 ? 8'sd127 : r < -64'sd127 ? -8'sd127 : r[7:0];
    end
    // control FSM; done lands in the first cycle both pipeline stages are empty
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            scale_max_abs <= '0;
            num_q         <= '0;
            cnt           <= '0;
            recip_q       <= '0;
            done          <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (cfg_start) begin
                    scale_max_abs <= cfg_max_abs;
                    num_q         <= cfg_num_elems;
                    cnt           <= '0;
                    state         <= REQ;
                end
                REQ: state <= WAIT;
                WAIT: if (scale_ready) begin
                    recip_q <= reciprocal_scale;
                    if (num_q == '0) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end else begin
                        state <= STREAM;
                    end
                end
                STREAM: if (accept) begin
                    cnt <= cnt + 1'b1;
                    if (cnt == num_q - 1'b1) state <= DRAIN;
                end
                DRAIN: if (!s1_valid && (!out_valid || out_ready)) begin
                    state <= IDLE;
                    done  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
    // two-stage pipeline, frozen as a whole while the output is back-pressured
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid  <= 1'b0;
            s1_prod   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (!stall) begin
            s1_valid  <= accept;
            if (accept) s1_prod <= prod;
            out_valid <= s1_valid;
            if (s1_valid) out_data <= q;
        end
    end
endmodule

// File: tb/tb_tensor_quantizer.sv
// tb_tensor_quantizer: directed tensors checked against an arithmetic quantization model
module tb_tensor_quantizer;
    localparam int CNT_W = 16;
    logic clk = 0, reset_n = 0, cfg_start = 0, scale_ready = 0, in_valid = 0, out_ready = 1;
    logic [31:0] cfg_max_abs = 0, reciprocal_scale = 0, in_data = 0;
    logic [CNT_W-1:0] cfg_num_elems = 0;
    logic scale_start, in_ready, out_valid, busy, done;
    logic [31:0] scale_max_abs;
    logic [7:0] out_data;

    tensor_quantizer #(.CNT_W(CNT_W), .FRAC_BITS(24)) dut (
        .clk(clk), .reset_n(reset_n), .cfg_start(cfg_start), .cfg_max_abs(cfg_max_abs),
        .cfg_num_elems(cfg_num_elems), .scale_start(scale_start), .scale_max_abs(scale_max_abs),
        .scale_ready(scale_ready), .reciprocal_scale(reciprocal_scale), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0, cyc = 0;
    int n_starts = 0, n_done = 0, done_cyc = 0, last_hs = 0, rc = 0;
    int st_lo = 0, st_hi = 0;
    logic [31:0] cur_recip = 0;
    int exp_q[$], obs_q[$];
    bit stalled_prev = 0;
    int prev_data = 0;

    task automatic chk(string name, longint act, longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // q = clamp(floor(x*recip/2^24 + 1/2), -127, 127), by plain integer division
    function automatic int quant(int x, logic [31:0] recip);
        longint rl, n, d, qv;
        rl = recip;
        n = longint'(x) * rl + 64'sd8388608;
        d = n / 64'sd16777216;
        if (n % 64'sd16777216 != 0 && n < 0) d = d - 1;
        qv = d > 127 ? 127 : d < -127 ? -127 : d;
        return int'(qv);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1 out_ready = !(cyc >= st_lo && cyc < st_hi);
    end

    always @(negedge clk) begin
        if (!reset_n) begin
            stalled_prev = 0;
        end else begin
            if (scale_start) n_starts++;
            if (in_valid && in_ready) exp_q.push_back(quant(in_data, cur_recip));
            if (stalled_prev) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", $signed(out_data), prev_data);
            end
            if (out_valid && !out_ready) chk("in_ready_stall", in_ready, 0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("extra_output", 1, 0);
                else chk("out_data", $signed(out_data), exp_q.pop_front());
                obs_q.push_back($signed(out_data));
                last_hs = cyc;
            end
            stalled_prev = out_valid && !out_ready;
            prev_data = $signed(out_data);
            if (done) begin
                n_done++;
                done_cyc = cyc;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic start_tensor(logic [31:0] max, int num);
        @(posedge clk); #1;
        cfg_max_abs = max; cfg_num_elems = CNT_W'(num); cfg_start = 1;
        @(posedge clk); #1;
        cfg_start = 0;
    endtask

    task automatic give_scale(int n0, logic [31:0] recip, logic [31:0] max);
        int t = 0;
        while (n_starts == n0 && t < 20) begin @(posedge clk); t++; end
        chk("scale_start_seen", n_starts - n0, 1);
        chk("scale_max_abs", scale_max_abs, max);
        @(posedge clk); #1;
        scale_ready = 1; reciprocal_scale = recip; cur_recip = recip;
        @(negedge clk) rc = cyc;
        @(posedge clk); #1;
        scale_ready = 0; reciprocal_scale = 32'hDEAD_BEEF;
    endtask

    task automatic feed(input int xs[$], input bit extra);
        foreach (xs[i]) begin
            bit acc = 0;
            int t = 0;
            in_valid = 1; in_data = xs[i];
            while (!acc && t < 60) begin
                @(negedge clk) acc = in_ready;
                @(posedge clk); #1;
                t++;
            end
            if (!acc) chk("accept_timeout", 0, 1);
        end
        if (extra) begin
            in_valid = 1; in_data = 32'd1234;
            repeat (3) begin @(negedge clk); chk("no_accept_after_count", in_ready, 0); end
            @(posedge clk); #1;
        end
        in_valid = 0;
    endtask

    task automatic run_tensor(string tag, logic [31:0] max, logic [31:0] recip,
                              input int xs[$], input int lit[$], input bit poke, input bit bp);
        int n0, nd0, t;
        n0 = n_starts; nd0 = n_done; t = 0;
        obs_q.delete();
        start_tensor(max, xs.size());
        if (poke) begin
            @(posedge clk); #1;
            cfg_max_abs = 32'd999; cfg_num_elems = 7; cfg_start = 1;
            @(posedge clk); #1;
            cfg_start = 0;
            chk({tag, "_busy_ignore_max"}, scale_max_abs, max);
        end
        give_scale(n0, recip, max);
        if (bp) begin st_lo = cyc + 4; st_hi = st_lo + 5; end
        feed(xs, 1);
        while (n_done == nd0 && t < 200) begin @(posedge clk); t++; end
        repeat (3) @(posedge clk);
        chk({tag, "_done_count"}, n_done - nd0, 1);
        chk({tag, "_done_time"}, done_cyc, xs.size() > 0 ? last_hs + 1 : rc + 1);
        chk({tag, "_idle"}, busy, 0);
        chk({tag, "_start_count"}, n_starts - n0, 1);
        chk({tag, "_leftover"}, exp_q.size(), 0);
        chk({tag, "_out_count"}, obs_q.size(), lit.size());
        foreach (lit[i]) if (i < obs_q.size()) chk({tag, "_literal"}, obs_q[i], lit[i]);
    endtask

    initial begin
        int xs[$], lit[$];
        int nd0;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_scale_start", scale_start, 0);
        chk("rst_done", done, 0);
        chk("rst_scale_max_abs", scale_max_abs, 0);
        reset_n = 1;

        xs = {100, -254, 300, 3}; lit = {50, -127, 127, 2};
        run_tensor("basic", 254, 32'd8388608, xs, lit, 0, 0);

        xs = {5, -7, 2147483647}; lit = {0, 0, 0};
        run_tensor("zero_max", 0, 0, xs, lit, 0, 0);

        xs.delete(); lit.delete();
        run_tensor("empty", 5, 32'd123, xs, lit, 0, 0);

        xs = {10, -20, 30, -40, 50, -60, 70, -128}; lit = {10, -20, 30, -40, 50, -60, 70, -127};
        run_tensor("backpressure", 127, 32'd16777216, xs, lit, 0, 1);

        nd0 = n_done;
        start_tensor(100, 8);
        give_scale(n_starts - 1, 32'd16777216, 100);
        xs = {1, 2, 3};
        feed(xs, 0);
        @(posedge clk); #1;
        reset_n = 0;
        #1;
        chk("mid_busy", busy, 0);
        chk("mid_in_ready", in_ready, 0);
        chk("mid_out_valid", out_valid, 0);
        chk("mid_out_data", out_data, 0);
        chk("mid_scale_max_abs", scale_max_abs, 0);
        chk("mid_done", done, 0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1;
        exp_q.delete();
        repeat (3) @(posedge clk);
        chk("mid_no_done", n_done - nd0, 0);

        xs = {-3, -1, 1}; lit = {-1, 0, 1};
        run_tensor("rounding", 254, 32'd8388608, xs, lit, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
